// File: rtl/vga_bars_pkg.sv
// vga_bars_pkg: shared widths, default timing, colour constants and the
// divider-boundary clamp used by the bar renderer and its sync counter.
package vga_bars_pkg;

    // Default 640x480 @ 60 Hz timing, counted in pixel clocks / lines.
    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_CENTER_COL  = 320;
    localparam int DEF_LINE_WIDTH  = 4;

    localparam int SPLIT_W = 9;             // signed split-line offset
    localparam int COLOR_W = 3;             // bits per colour channel
    localparam int RGB_W   = 3 * COLOR_W;   // packed {R,G,B}
    localparam int BOUND_W = 11;            // signed width for boundary maths

    localparam logic [RGB_W-1:0] DEF_LEFT_COLOR    = 9'o700;
    localparam logic [RGB_W-1:0] DEF_RIGHT_COLOR   = 9'o007;
    localparam logic [RGB_W-1:0] DEF_LINE_COLOR    = 9'o777;
    localparam logic [RGB_W-1:0] CENTER_MARK_COLOR = 9'o070;

    // Position recovery: hunting for the first frame start, then tracking.
    typedef enum logic {
        LOCK_HUNT  = 1'b0,
        LOCK_TRACK = 1'b1
    } lock_state_e;

    // Clamp a signed boundary column into the visible range [0, max_col].
    function automatic logic signed [BOUND_W-1:0] clamp_bound(
        input logic signed [BOUND_W-1:0] raw,
        input int                        max_col
    );
        logic signed [BOUND_W-1:0] hi;
        hi = BOUND_W'(max_col);
        if (raw[BOUND_W-1]) begin
            return '0;
        end
        if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: detects the VSync rising edge (frame start) and runs
// column/row counters that are re-aligned on every frame start. Reports
// lock once the first frame start after reset has been seen.
module vga_sync_counter
    import vga_bars_pkg::*;
#(
    parameter int TOTAL_COLS = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
    parameter int COL_W      = $clog2(TOTAL_COLS),
    parameter int ROW_W      = $clog2(TOTAL_ROWS)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_VSync,
    output logic [COL_W-1:0] o_Col,
    output logic [ROW_W-1:0] o_Row,
    output logic             o_Locked
);

    logic             vsync_d_reg;
    logic             frame_start;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    lock_state_e      state_reg, state_next;

    assign frame_start = i_VSync & ~vsync_d_reg;

    // State, edge-detect and counter registers. The VSync history resets
    // high so that releasing reset in the middle of an active region does
    // not look like a frame start; lock waits for a genuine rising edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vsync_d_reg <= 1'b1;
            col_reg     <= '0;
            row_reg     <= '0;
            state_reg   <= LOCK_HUNT;
        end else begin
            vsync_d_reg <= i_VSync;
            col_reg     <= col_next;
            row_reg     <= row_next;
            state_reg   <= state_next;
        end
    end

    // Next position: frame start re-aligns to (0,0) and wins over wrap.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (frame_start) begin
            col_next = '0;
            row_next = '0;
        end else if (col_reg == COL_W'(TOTAL_COLS - 1)) begin
            col_next = '0;
            if (row_reg == ROW_W'(TOTAL_ROWS - 1)) begin
                row_next = '0;
            end else begin
                row_next = row_reg + ROW_W'(1);
            end
        end else begin
            col_next = col_reg + COL_W'(1);
        end
    end

    // Lock FSM: any frame start moves to tracking; only reset returns to hunt.
    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = LOCK_TRACK;
        end
    end

    assign o_Col    = col_reg;
    assign o_Row    = row_reg;
    assign o_Locked = (state_reg == LOCK_TRACK);

endmodule

// File: rtl/vga_bar_renderer.sv
// vga_bar_renderer: paints a left/right two-colour bar screen with a
// divider line at CENTER_COL + split. The split offset is shadowed once
// per frame during vertical blanking so the divider never tears, and the
// syncs are delayed two cycles to stay aligned with the registered colour.
// Optional build macro VGA_BARS_CENTER_MARK_EN adds a green reference
// mark at CENTER_COL on non-divider active pixels.
module vga_bar_renderer
    import vga_bars_pkg::*;
#(
    parameter int               TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int               TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int               ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int               ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int               CENTER_COL  = DEF_CENTER_COL,
    parameter int               LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter logic [RGB_W-1:0] LEFT_COLOR  = DEF_LEFT_COLOR,
    parameter logic [RGB_W-1:0] RIGHT_COLOR = DEF_RIGHT_COLOR,
    parameter logic [RGB_W-1:0] LINE_COLOR  = DEF_LINE_COLOR
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_HSync,
    input  logic                      i_VSync,
    input  logic signed [SPLIT_W-1:0] i_SplitLine,
    output logic                      o_NewFrameTick,
    output logic                      o_HSync,
    output logic                      o_VSync,
    output logic [COLOR_W-1:0]        o_Red_Video,
    output logic [COLOR_W-1:0]        o_Grn_Video,
    output logic [COLOR_W-1:0]        o_Blu_Video
);

    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);

    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic                      locked;

    logic signed [SPLIT_W-1:0] split_reg;
    logic [1:0]                hsync_pipe_reg, vsync_pipe_reg;
    logic [RGB_W-1:0]          rgb_reg, rgb_next;
    logic                      tick_reg, tick_next;
    logic                      split_load;

    logic signed [BOUND_W-1:0] bound_raw, bound, line_end, col_s;
    logic                      active, in_line;

    vga_sync_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_sync_counter (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_VSync  (i_VSync),
        .o_Col    (col),
        .o_Row    (row),
        .o_Locked (locked)
    );

    // Divider geometry from the shadowed split, in signed 11-bit arithmetic.
    assign bound_raw = $signed(BOUND_W'(CENTER_COL)) + BOUND_W'(split_reg);
    assign bound     = clamp_bound(bound_raw, ACTIVE_COLS - 1);
    assign line_end  = bound + $signed(BOUND_W'(LINE_WIDTH));
    assign col_s     = $signed(BOUND_W'(col));
    assign active    = (col < COL_W'(ACTIVE_COLS)) && (row < ROW_W'(ACTIVE_ROWS));
    assign in_line   = (col_s >= bound) && (col_s < line_end);

    // Tick at the first pixel of vertical blanking; split is taken one line
    // later so the producer has had a full line to settle its new value.
    assign tick_next  = locked && (col == '0) && (row == ROW_W'(ACTIVE_ROWS));
    assign split_load = locked && (col == '0) && (row == ROW_W'(ACTIVE_ROWS + 1));

    // Colour selection for the current position; black until locked.
    always_comb begin
        rgb_next = '0;
        if (locked && active) begin
            if (col_s < bound) begin
                rgb_next = LEFT_COLOR;
            end else if (in_line) begin
                rgb_next = LINE_COLOR;
            end else begin
                rgb_next = RIGHT_COLOR;
            end
`ifdef VGA_BARS_CENTER_MARK_EN
            if ((col == COL_W'(CENTER_COL)) && !in_line) begin
                rgb_next = CENTER_MARK_COLOR;
            end
`else
`endif
        end
    end

    // Output stage: colour, tick, split shadow and the two-deep sync delay.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rgb_reg        <= '0;
            tick_reg       <= 1'b0;
            split_reg      <= '0;
            hsync_pipe_reg <= '0;
            vsync_pipe_reg <= '0;
        end else begin
            rgb_reg        <= rgb_next;
            tick_reg       <= tick_next;
            hsync_pipe_reg <= {hsync_pipe_reg[0], i_HSync};
            vsync_pipe_reg <= {vsync_pipe_reg[0], i_VSync};
            if (split_load) begin
                split_reg <= i_SplitLine;
            end
        end
    end

    assign o_NewFrameTick = tick_reg;
    assign o_HSync        = hsync_pipe_reg[1];
    assign o_VSync        = vsync_pipe_reg[1];
    assign o_Red_Video    = rgb_reg[RGB_W-1 -: COLOR_W];
    assign o_Grn_Video    = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign o_Blu_Video    = rgb_reg[COLOR_W-1:0];

endmodule

// File: doc/vga_bar_renderer.md
Name: vga_bar_renderer

Overview:
Consumer end of the demo-bar split-line interface. Recovers column/row position from the VGA active-region sync signals and emits the once-per-frame tick that drives the sine split-line generator. Samples the signed split line once per frame into a shadow register and paints a two-colour bar screen with a divider line at CENTER_COL + split, delaying sync outputs to stay aligned with colour. Sits between the sync-pulse generator and the board VGA pins.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
CENTER_COL, 320, column the split offset is added to
LINE_WIDTH, 4, divider width in pixels (1..16)
LEFT_COLOR, 9'o700, {R,G,B} 3 bits each, used left of divider
RIGHT_COLOR, 9'o007, used right of divider
LINE_COLOR, 9'o777, used for divider

Ports:
i_Clk  in  1  pixel clock (25.175 MHz class)
i_Rst_L  in  1  asynchronous active-low reset
i_HSync  in  1  high while current column < ACTIVE_COLS
i_VSync  in  1  high while current row < ACTIVE_ROWS; rising edge = frame start
i_SplitLine  in  9 signed  divider offset from CENTER_COL, range -256..255
o_NewFrameTick  out  1  one-cycle pulse, once per frame
o_HSync  out  1  i_HSync delayed 2 cycles
o_VSync  out  1  i_VSync delayed 2 cycles
o_Red_Video  out  3  red
o_Grn_Video  out  3  green
o_Blu_Video  out  3  blue

Behaviour:
- Reset (async assert, sync release): counters 0, r_SplitLine 0, r_Locked 0, all outputs 0, sync delay chain 0.
- Frame start = i_VSync & ~r_VSync_d (r_VSync_d is i_VSync registered). On frame start: col<=0, row<=0, r_Locked<=1. Otherwise col increments; col==TOTAL_COLS-1 wraps to 0 and increments row; row==TOTAL_ROWS-1 wraps to 0.
- Before r_Locked: video forced to 0, o_NewFrameTick held 0; sync delay chain still runs.
- o_NewFrameTick: 1 for exactly one cycle when locked and col==0, row==ACTIVE_ROWS (start of vertical blanking).
- Split sample: when locked and col==0, row==ACTIVE_ROWS+1 (one line after the tick, so the producer has settled), r_SplitLine<=i_SplitLine. r_SplitLine is constant throughout every active region (no tearing).
- Boundary b = CENTER_COL + r_SplitLine, 11-bit signed arithmetic, clamped to [0, ACTIVE_COLS-1].
- Colour (registered): outside active (col>=ACTIVE_COLS or row>=ACTIVE_ROWS) -> 0; col<b -> LEFT_COLOR; b<=col<b+LINE_WIDTH -> LINE_COLOR; else RIGHT_COLOR. Divider columns beyond ACTIVE_COLS-1 are simply not drawn.
- Latency: input sync at cycle t -> counter valid t+1 -> colour and delayed syncs at t+2, aligned.
- Counter free-run frame start coinciding with wrap: frame start wins.
- Reset mid-frame: black until the next i_VSync rising edge, then normal.

Optional Feature:
VGA_BARS_CENTER_MARK_EN: when defined, active pixels at col==CENTER_COL that are not divider pixels show 9'o070 (green reference mark). When undefined, no mark; logic absent.

Decomposition:
- Package vga_bars_pkg: timing defaults (800/525/640/480), SPLIT_W=9, COLOR_W=3, colour constants, CENTER_MARK_COLOR.
- Sub-module vga_sync_counter: VSync edge detect, col/row counters, r_Locked. Top level holds split shadow, clamp, colour mux, sync delay chain.

Test Plan:
- Reset then no VSync edge for 2 frames -> all video 0, o_NewFrameTick never asserted.
- Standard 800x525 sync stream, i_SplitLine=0 -> cols 0..319 LEFT, 320..323 WHITE (9'o777), 324..639 RIGHT, blanking 0; exactly one tick per 420000 cycles, at row 480 col 0.
- i_SplitLine=+200 applied mid-active-region -> current frame unchanged; next frame divider at cols 520..523.
- i_SplitLine=-256 -> b clamps to 64; i_SplitLine=255 -> divider at cols 575..578; force CENTER_COL=600, split=100 -> b=639, only col 639 LINE_COLOR.
- i_Rst_L low for 10 cycles at row 200 -> outputs 0 immediately (async), black until next VSync rise, then correct frame.
- Check o_HSync/o_VSync equal inputs delayed 2 cycles; with VGA_BARS_CENTER_MARK_EN and split=+50, col 320 shows 9'o070.
